apb_master_ctrl: RTL and testbench
==================================

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PADDR/cmd_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, PWDATA/PRDATA/data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS cycles without PREADY; 0 disables timeout.
REQ-004 SHALL have ports as follows; reset PRESETn, asynchronous, active-low; clock PCLK.
REQ-005 PCLK  input  1  bus clock; all logic on rising edge.
REQ-006 PRESETn  input  1  asynchronous active-low reset.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-009 cmd_write  input  1  1=write, 0=read.
REQ-010 cmd_addr  input  ADDR_WIDTH  target address.
REQ-011 cmd_wdata  input  DATA_WIDTH  write data.
REQ-012 cmd_prot  input  3  protection attributes.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-015 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
REQ-016 rsp_err  output  1  PSLVERR seen or timeout.
REQ-017 rsp_timeout  output  1  transfer aborted by timeout.
REQ-018 PADDR, PPROT(3), PNSE(1), PSEL(1), PENABLE(1), PWRITE(1), PWDATA  outputs  APB requester signals.
REQ-019 PRDATA (DATA_WIDTH), PREADY(1), PSLVERR(1)  inputs  APB completer signals.

Function
REQ-020 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; all APB and rsp outputs registered.
REQ-021 IDLE: cmd_ready=1, PSEL=0, PENABLE=0; on accept, latch cmd fields into PADDR/PWRITE/PWDATA/PPROT, go SETUP.
REQ-022 cmd_ready SHALL be 0 in SETUP, ACCESS, RESP; one transfer outstanding max.
REQ-023 SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
REQ-024 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE, PWDATA, PPROT stable from SETUP until exit.
REQ-025 ACCESS with PREADY=1 at clock edge: capture PRDATA (reads only) and PSLVERR into rsp_*, drop PSEL/PENABLE, go RESP.
REQ-026 PSLVERR SHALL be sampled only in ACCESS with PREADY=1; ignored elsewhere.
REQ-027 Wait counter SHALL clear on SETUP entry, increment each ACCESS cycle with PREADY=0.
REQ-028 Counter reaching TIMEOUT_CYCLES SHALL abort: PSEL/PENABLE to 0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go RESP.
REQ-029 PREADY=1 on the same edge the counter would reach TIMEOUT_CYCLES SHALL count as normal completion, no timeout.
REQ-030 RESP: rsp_valid=1, rsp_* held stable until rsp_ready=1; then rsp_valid=0, go IDLE next cycle.
REQ-031 Minimum transfer: accept edge, SETUP 1 cycle, ACCESS >=1 cycle, RESP >=1 cycle; back-to-back command accepted in the IDLE cycle following RESP.
REQ-032 PNSE SHALL be driven 0 constantly.
REQ-033 PADDR/PWDATA SHALL retain last values while idle (no bus glitch requirement beyond PSEL=0).

Reset
REQ-034 PRESETn low SHALL asynchronously force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PPROT=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0.
REQ-035 Reset mid-transfer SHALL abandon the transfer with no response generated; cmd_ready=1 on first cycle after release.

Verification
REQ-036 Write: cmd addr=0x08 wdata=0xA5, completer PREADY one cycle into ACCESS -> SETUP 1 cycle, ACCESS 2 cycles, rsp_valid with rsp_err=0, rsp_rdata=0.
REQ-037 Read: cmd addr=0x08 after above, completer returns 0xA5 -> rsp_rdata=0xA5, rsp_err=0.
REQ-038 Wait states: PREADY held low 5 cycles -> PADDR/PWDATA/PWRITE stable throughout, completes on 6th ACCESS cycle, no timeout.
REQ-039 Timeout: PREADY never asserted, TIMEOUT_CYCLES=16 -> PSEL drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1.
REQ-040 Error/backpressure: PSLVERR=1 with PREADY, rsp_ready low 3 cycles -> rsp_err=1 held 3 cycles, cmd_ready=0 until consumed.
REQ-041 Reset in ACCESS -> PSEL/PENABLE 0 immediately, no rsp_valid, next command completes normally.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// APB requester: turns one command at a time into an APB SETUP/ACCESS transfer
// and returns the result on a response channel, with an optional wait-state timeout.
module apb_master_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    // Handshakes: a beat transfers on a rising PCLK edge where valid && ready;
    // the sender holds valid and its payload stable until that edge.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [2:0]            PPROT,
    output logic                  PNSE,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic [1:0]            fsm_state
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Count value at which one more unready ACCESS cycle exhausts the budget.
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    assign fsm_state = state;
    assign PNSE      = 1'b0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PPROT       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        PADDR     <= cmd_addr;
                        PWRITE    <= cmd_write;
                        PWDATA    <= cmd_wdata;
                        PPROT     <= cmd_prot;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        cmd_ready <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // PREADY wins over a timeout landing on the same edge.
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= S_RESP;
                    end else if (TIMEOUT_CYCLES > 0 && wait_cnt == TO_LAST) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        wait_cnt    <= wait_cnt + 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: drives commands and a scripted APB completer,
// a negedge monitor checks every response beat against an expected queue.
module tb_apb_master_ctrl;

    localparam int AW = 32;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] PADDR;
    logic [2:0]    PPROT;
    logic          PNSE, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic [1:0]    fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    // {err, timeout, rdata}
    logic [DW+1:0] exp_q[$];

    apb_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PPROT(PPROT), .PNSE(PNSE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .fsm_state(fsm_state)
    );

    // Clock and reset
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Monitor: every response handshake pops one expected entry
    always @(negedge PCLK) begin
        if (PRESETn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                logic [DW+1:0] e;
                e = exp_q.pop_front();
                chk("rsp_err",     64'(rsp_err),     64'(e[DW+1]));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(e[DW]));
                chk("rsp_rdata",   64'(rsp_rdata),   64'(e[DW-1:0]));
            end
        end
    end

    // One full transfer. waits < 0 means the completer never raises PREADY.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [2:0] prot, input int waits, input logic slverr,
                        input logic [DW-1:0] rdata, input int rsp_delay);
        int acc;
        int exp_acc;
        logic to;
        logic [DW-1:0] erd;
        to      = (waits < 0) || (waits >= TO);
        exp_acc = to ? TO : waits + 1;
        erd     = (wr || to) ? '0 : rdata;
        exp_q.push_back({(slverr | to), to, erd});

        chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_prot = prot;
        step();
        cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wdata;
        chk("setup_psel",    64'(PSEL),      64'(1));
        chk("setup_penable", 64'(PENABLE),   64'(0));
        chk("setup_ready",   64'(cmd_ready), 64'(0));
        chk("setup_paddr",   64'(PADDR),     64'(addr));
        acc = 0;
        while (acc <= 40) begin
            step();
            if (!(PSEL && PENABLE)) break;
            acc++;
            if (PADDR !== addr || PWRITE !== wr || PPROT !== prot || (wr && PWDATA !== wdata))
                chk("access_stable", 64'({PADDR, PWRITE, PPROT}), 64'({addr, wr, prot}));
            if (waits >= 0 && acc == waits + 1) begin
                PREADY = 1'b1; PSLVERR = slverr; PRDATA = rdata;
            end else begin
                // junk that must be ignored while PREADY is low
                PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 8'hEE;
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        chk("access_cycles", 64'(acc),       64'(exp_acc));
        chk("resp_psel",     64'(PSEL),      64'(0));
        chk("resp_valid",    64'(rsp_valid), 64'(1));
        for (int d = 0; d < rsp_delay; d++) begin
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_err",   64'(rsp_err),   64'(slverr | to));
            chk("hold_ready", 64'(cmd_ready), 64'(0));
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("post_valid", 64'(rsp_valid), 64'(0));
        chk("post_ready", 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_prot = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #12;
        chk("rst_psel",      64'(PSEL),      64'(0));
        chk("rst_penable",   64'(PENABLE),   64'(0));
        chk("rst_paddr",     64'(PADDR),     64'(0));
        chk("rst_pwdata",    64'(PWDATA),    64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_state",     64'(fsm_state), 64'(0));
        step();
        PRESETn = 1'b1;
        step();
        chk("pnse", 64'(PNSE), 64'(0));

        //    wr    addr        wdata  prot  waits slverr rdata  rsp_delay
        xfer(1'b1, 32'h08,     8'hA5, 3'd2,  1,    1'b0,  8'h00, 0);
        xfer(1'b0, 32'h08,     8'h00, 3'd0,  1,    1'b0,  8'hA5, 0);
        xfer(1'b1, 32'h10,     8'h3C, 3'd5,  5,    1'b0,  8'h00, 1);
        xfer(1'b0, 32'h14,     8'h00, 3'd1, -1,    1'b0,  8'h99, 0);
        xfer(1'b1, 32'h20,     8'h5A, 3'd7,  0,    1'b1,  8'h00, 3);
        xfer(1'b0, 32'hDEAD00, 8'h00, 3'd3, 15,    1'b0,  8'hC3, 0);
        xfer(1'b0, 32'h30,     8'h00, 3'd4,  2,    1'b1,  8'h77, 2);

        // Reset while the completer is stalling in ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 8'h11; cmd_prot = 3'd6;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("pre_rst_access", 64'(PSEL && PENABLE), 64'(1));
        PRESETn = 1'b0;
        #1;
        chk("midrst_psel",    64'(PSEL),      64'(0));
        chk("midrst_penable", 64'(PENABLE),   64'(0));
        chk("midrst_valid",   64'(rsp_valid), 64'(0));
        chk("midrst_paddr",   64'(PADDR),     64'(0));
        step();
        PRESETn = 1'b1;
        step();
        chk("postrst_ready", 64'(cmd_ready), 64'(1));
        chk("postrst_valid", 64'(rsp_valid), 64'(0));

        xfer(1'b0, 32'h08, 8'h00, 3'd0, 0, 1'b0, 8'h5C, 0);

        step();
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
